// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack gate-level self-test checkers.
// Holds the checker state enum and the settle counter width.
package hack_pkg;

  localparam int HACK_MAX_IN   = 4;
  localparam int HACK_SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } chk_state_t;

endpackage

// File: rtl/hack_settle_counter.sv
// Settle-interval down-counter shared by the Hack checkers.
// Ports: clk, reset (sync, high), load_i/value_i preload, en_i count, expired_o at zero.
module hack_settle_counter
  import hack_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_i,
  input  logic                     en_i,
  input  logic [HACK_SETTLE_W-1:0] value_i,
  output logic                     expired_o
);

  logic [HACK_SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/hack_gate_checker.sv
// Walks every input vector of a 1..4 input gate and checks it against a truth table.
// Ports: clk, reset, start in; dut_in/dut_out gate link; busy, done, pass, err_count, first_fail_* out.
module hack_gate_checker
  import hack_pkg::*;
#(
  parameter int                  N_IN     = 2,
  parameter int                  SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 'b1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  // Counter preload so WAIT lasts exactly SETTLE cycles.
  localparam logic [HACK_SETTLE_W-1:0] SETTLE_LD =
    (SETTLE == 0) ? '0 : HACK_SETTLE_W'(SETTLE - 1);

  chk_state_t      state_q, state_d;
  logic [N_IN-1:0] din_q, din_d;
  logic [N_IN:0]   err_q, err_d, err_nxt;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            pass_q, pass_d;
  logic            mism;
  logic            cnt_load;
  logic            cnt_exp;

  hack_settle_counter u_settle (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .en_i      (state_q == WAIT),
    .value_i   (SETTLE_LD),
    .expired_o (cnt_exp)
  );

  // Case-inequality so an X/Z gate output is flagged.
  assign mism    = (dut_out !== EXPECTED[din_q]);
  assign err_nxt = err_q + {{N_IN{1'b0}}, mism};

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    pass_d   = pass_q;
    cnt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          din_d  = '0;
          err_d  = '0;
          ffv_d  = 1'b0;
          ffi_d  = '0;
          pass_d = 1'b0;
          if (SETTLE == 0) begin
            state_d = SAMPLE;
          end else begin
            state_d  = WAIT;
            cnt_load = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_exp) state_d = SAMPLE;
      end
      SAMPLE: begin
        err_d = err_nxt;
        if (mism && !ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = din_q;
        end
        if (&din_q) begin
          state_d = DONE;
          pass_d  = (err_nxt == '0);
          din_d   = '0;
        end else begin
          din_d = din_q + 1'b1;
          if (SETTLE != 0) begin
            state_d  = WAIT;
            cnt_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      din_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in           = din_q;
  assign busy             = (state_q == WAIT) || (state_q == SAMPLE);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule
